// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/execute control FSM for the 4-bit-address teaching
// computer. It steps the PC (increment, absolute jump, PC-relative branch),
// latches fetched instructions into the IR, and drives register-file, ALU and
// data-memory controls, including a req/ack handshake to data memory.
// Only the state and the IR are registered. All other outputs are decoded
// combinationally from state, IR, Z, N and MEM_ACK.
module pc_sequencer (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       run_i,
  input  logic [9:0] instr_i,
  input  logic       z_i,
  input  logic       n_i,
  input  logic       mem_ack_i,
  output logic [9:0] ir_o,
  output logic [1:0] pc_sel_o,
  output logic [3:0] pc_tgt_o,
  output logic [2:0] alu_fs_o,
  output logic       rf_we_o,
  output logic       rf_src_o,
  output logic       mem_req_o,
  output logic       mem_we_o,
  output logic       halted_o
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_FETCH    = 3'd1;
  localparam logic [2:0] S_EXEC     = 3'd2;
  localparam logic [2:0] S_MEM_WAIT = 3'd3;
  localparam logic [2:0] S_HALT     = 3'd4;

  localparam logic [3:0] OP_LD   = 4'b1000;
  localparam logic [3:0] OP_ST   = 4'b1001;
  localparam logic [3:0] OP_JMP  = 4'b1010;
  localparam logic [3:0] OP_BZ   = 4'b1011;
  localparam logic [3:0] OP_BN   = 4'b1100;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam logic [1:0] PC_HOLD = 2'b00;
  localparam logic [1:0] PC_INC  = 2'b01;
  localparam logic [1:0] PC_LOAD = 2'b10;
  localparam logic [1:0] PC_REL  = 2'b11;

  logic [2:0] state_q, state_d;
  logic [9:0] ir_q, ir_d;
  logic [3:0] op;

  assign op   = ir_q[9:6];
  assign ir_o = ir_q;

  // Next-state and IR-load logic.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      S_IDLE: begin
        if (run_i) state_d = S_FETCH;
      end
      S_FETCH: begin
        ir_d    = instr_i;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        case (op)
          OP_LD, OP_ST: state_d = S_MEM_WAIT;
          OP_HALT:      state_d = S_HALT;
          default:      state_d = run_i ? S_FETCH : S_IDLE;
        endcase
      end
      S_MEM_WAIT: begin
        // RUN only gates the next fetch; an outstanding transfer always completes.
        if (mem_ack_i) state_d = run_i ? S_FETCH : S_IDLE;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control decode. Branch flags count only in EXEC, and MEM_ACK only in MEM_WAIT.
  always_comb begin
    pc_sel_o  = PC_HOLD;
    pc_tgt_o  = 4'd0;
    alu_fs_o  = 3'd0;
    rf_we_o   = 1'b0;
    rf_src_o  = 1'b0;
    mem_req_o = 1'b0;
    mem_we_o  = 1'b0;
    halted_o  = 1'b0;
    case (state_q)
      S_FETCH: begin
        pc_sel_o = PC_INC;
      end
      S_EXEC: begin
        if (!op[3]) begin
          alu_fs_o = op[2:0];
          rf_we_o  = 1'b1;
        end else begin
          case (op)
            OP_LD:   mem_req_o = 1'b1;
            OP_ST: begin
              mem_req_o = 1'b1;
              mem_we_o  = 1'b1;
            end
            OP_JMP:  pc_sel_o = PC_LOAD;
            OP_BZ:   pc_sel_o = z_i ? PC_REL : PC_HOLD;
            OP_BN:   pc_sel_o = n_i ? PC_REL : PC_HOLD;
            default: pc_sel_o = PC_HOLD;
          endcase
        end
      end
      S_MEM_WAIT: begin
        mem_req_o = 1'b1;
        mem_we_o  = (op == OP_ST);
        if (mem_ack_i && (op == OP_LD)) begin
          rf_we_o  = 1'b1;
          rf_src_o = 1'b1;
        end
      end
      S_HALT: begin
        halted_o = 1'b1;
      end
      default: begin
        pc_sel_o = PC_HOLD;
      end
    endcase
    // The target field is meaningful only for a load or a relative add.
    if (pc_sel_o[1]) pc_tgt_o = ir_q[3:0];
  end

  // State and instruction register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      ir_q    <= 10'd0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from pre-edge values.
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch/execute control state machine for the 4-bit-address teaching computer. It sequences the program counter (increment, absolute jump, PC-relative branch) and latches each fetched instruction into an internal instruction register. It issues register-file, ALU and data-memory controls, with a request/acknowledge handshake to data memory. It sits between instruction memory, the PC datapath and the register/ALU datapath.

## Interface
- No parameters; widths fixed: address 4, instruction 10, ALU function 3.
- CLK  in  1  single system clock, rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- RUN  in  1  level; 1 = allow new instruction fetches.
- INSTR  in  10  instruction word at current PC; fields OP[9:6], DR[5:4], SA[3:2], SB[1:0].
- Z, N  in  1 each  ALU status flags (zero, negative), held by datapath.
- MEM_ACK  in  1  data-memory transfer complete.
- IR  out  10  instruction register.
- PC_SEL  out  2  00 hold, 01 PC+1, 10 load PC_TGT, 11 PC+PC_TGT (mod 16).
- PC_TGT  out  4  {SA,SB} of IR; 0 when PC_SEL is 00 or 01.
- ALU_FS  out  3  ALU function = IR[8:6].
- RF_WE  out  1  register-file write of DR.
- RF_SRC  out  1  0 = ALU result, 1 = memory read data.
- MEM_REQ  out  1  data-memory request.
- MEM_WE  out  1  1 = store, 0 = load; valid with MEM_REQ.
- HALTED  out  1  sequencer stopped on HALT.

## Operation
- States: IDLE, FETCH, EXEC, MEM_WAIT, HALT. Registered: state, IR. All other outputs are combinational from state, IR, Z, N and MEM_ACK.
- IDLE: all controls 0. Goes to FETCH when RUN=1.
- FETCH: IR <= INSTR; PC_SEL=01. Goes to EXEC. PC therefore holds the next address during EXEC.
- EXEC decode on IR.OP:
  - 0xxx ALU: ALU_FS=OP[2:0], RF_WE=1, RF_SRC=0.
  - 1000 LD: MEM_REQ=1, MEM_WE=0, go to MEM_WAIT.
  - 1001 ST: MEM_REQ=1, MEM_WE=1, go to MEM_WAIT.
  - 1010 JMP: PC_SEL=10.
  - 1011 BZ: PC_SEL=11 if Z=1, else 00.
  - 1100 BN: PC_SEL=11 if N=1, else 00.
  - 1111 HALT: go to HALT.
  - 1101, 1110: NOP.
- Exit from EXEC for every non-memory, non-HALT opcode: FETCH if RUN=1, else IDLE.
- MEM_WAIT: MEM_REQ and MEM_WE held stable until MEM_ACK=1.
  - In the ack cycle, an LD asserts RF_WE=1, RF_SRC=1.
  - On ack, go to FETCH/IDLE by RUN, as from EXEC.
  - MEM_ACK sampled in EXEC is ignored.
- HALT: HALTED=1, all other controls 0. Left only by reset.
- Relative branch offset is unsigned 4-bit; PC+offset wraps mod 16 (offset 0 re-executes nothing; PC stays at the next instruction).
- Branch flags are sampled in the EXEC cycle only.
- RUN=0 never aborts an instruction in progress; it only blocks the next fetch.

## Timing
- Reset (async, any state): state=IDLE, IR=0. All outputs 0, including PC_SEL=00 and HALTED=0.
- First FETCH is the first rising edge with RUN=1 after reset release.
- Non-memory instruction: 2 cycles (FETCH, EXEC).
- LD/ST: 2 + k cycles, where k ≥ 1 is the number of MEM_WAIT cycles up to and including the ack cycle.
- PC_SEL from FETCH takes effect at the FETCH→EXEC edge. PC_SEL from EXEC takes effect at the EXEC exit edge.
- Reset asserted during MEM_WAIT: MEM_REQ drops immediately and the transfer is abandoned.

## Test plan
- Reset then RUN=1, INSTR=10'b0000_01_10_11 (ALU FS=000): FETCH asserts PC_SEL=01. Next cycle RF_WE=1, ALU_FS=000, RF_SRC=0. Then FETCH again. 2 cycles per instruction.
- JMP with IR=10'b1010_00_10_01: EXEC drives PC_SEL=10, PC_TGT=4'b1001.
- BZ offset 4'b0011: with Z=1, EXEC drives PC_SEL=11, PC_TGT=3. With Z=0, PC_SEL=00, PC_TGT=0. Repeat for BN with N.
- LD with MEM_ACK delayed 3 cycles: MEM_REQ=1, MEM_WE=0 held for 3 cycles. RF_WE=1, RF_SRC=1 only in the ack cycle. ST: MEM_WE=1 throughout, RF_WE never set.
- HALT (OP=1111): HALTED=1 and stays set regardless of RUN or INSTR. Pulse RST_N low: HALTED=0 and state is IDLE asynchronously.
- RUN dropped during an LD wait: the transfer completes on ack, then the sequencer enters IDLE with no further FETCH. Raising RUN resumes with FETCH.
